tx_ffe_source: RTL and testbench
================================

# tx_ffe_source

Emulated transmitter driving the channel filter input. It schedules one symbol event per UI on the shared emulation timeline and generates PRBS7 data. It applies a 3-tap FFE (pre/main/post) selected by `tx_setting` and presents the filter-format value and event strobe the channel filter consumes. It also proposes its next event time to the time manager.

## Interface
- `UI_PERIOD`, default 1000: UI length in TIME_FORMAT LSBs, unsigned, nonzero.
- `T0`, default 0: time of first symbol event.
- `PRBS_SEED`, default 7'h01: PRBS7 reset state, nonzero.
- `clk_sys`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `time_curr`  in  TIME_WIDTH  current emulation time, unsigned TIME_FORMAT.
- `tx_setting`  in  TX_SETTING_WIDTH  FFE tap-set index.
- `time_next_tx`  out  TIME_WIDTH  scheduled next event time, to time manager.
- `time_eq_out`  out  1  event strobe, connects to filter `time_eq_in`.
- `out`  out  FILTER_IN_WIDTH  signed FILTER_IN_FORMAT symbol value, connects to filter `in`.
- `bit_out`  out  1  current main-cursor bit, for BER checker.
- `err_late`  out  1  sticky: an event was serviced after its scheduled time.
- `err_ovf`  out  1  sticky: schedule saturated at end of time range.

## Operation
- State: `t_sched` (TIME_WIDTH), PRBS7 register, 3-bit window `{nxt, main, post}`, registered `out`, `bit_out`, `err_late`, `err_ovf`, `done`.
- `time_next_tx` = `t_sched` (direct register output).
- Event condition (combinational): `time_eq_out = !done && (time_curr >= t_sched)`, unsigned compare.
- On event edge:
  - PRBS7 advances: `fb = s[6]^s[5]`, `s <= {s[5:0], fb}`.
  - Window shifts: `{nxt, main, post} <= {fb, nxt, main}`.
  - Tap set latches from `tx_setting`. `tx_setting` changes between events have no effect until the next event.
  - If `time_curr > t_sched`, set `err_late`. The event is still serviced.
  - `t_sched <= t_sched + UI_PERIOD`. If the sum overflows TIME_WIDTH, load `t_sched` with all-ones and set `err_ovf` and `done`. No further events occur until reset.
- Output computed from the shifted window, bit b maps to symbol ±1 (1→+1, 0→−1):
  - `out = sgn(nxt)·C_PRE + sgn(main)·C_MAIN + sgn(post)·C_POST`.
  - Coefficients come from `TX_TAPS[setting]`, signed FILTER_IN_FORMAT.
  - Sum is formed at FILTER_IN_WIDTH+2 bits and saturated to FILTER_IN_WIDTH.
- `bit_out` = `main` after shift.
- Reset values:
  - `t_sched = T0`; PRBS = `PRBS_SEED`; window = 3'b000; tap set = 0.
  - `out = 0`; `bit_out = 0`; `err_late = 0`; `err_ovf = 0`; `done = 0`.
- Reset mid-run: all state returns to reset values on the next edge. A pending event in the reset cycle is discarded. `out` returns to 0.

## Timing
- `time_eq_out` is combinational from `time_curr` and `t_sched`. It is high in cycle N when the condition holds.
- `out` and `bit_out` update at the edge ending cycle N and are valid from cycle N+1. This matches the filter capturing value on delayed `time_eq_in`.
- `time_next_tx` updates at the same edge as `out`, so it is valid in N+1.
- Back-to-back events (`UI_PERIOD` smaller than the time-manager step) are handled one per cycle. Each serviced-late event sets `err_late`.
- Exactly one PRBS step per event. There is no lookahead other than the window's `nxt` bit.

## Structure
- `tx_package` holds:
  - `TX_SETTING_WIDTH`, `NUM_TX_SETTINGS`.
  - `TX_TAPS[NUM_TX_SETTINGS][3]`, typed FILTER_IN_FORMAT.
  - `PRBS7_SEED_DEFAULT`.
- TIME_FORMAT and FILTER_IN_FORMAT are reused from `time_package` and `signal_package`.
- One sub-module, `prbs7_gen` (clk, rst, advance, seed → fb, state).
- FFE add/subtract and saturation stay in the top level; no multipliers.

## Test plan
- Reset with T0=0, `time_curr` held at 0:
  - `time_eq_out`=1 in the first cycle after reset release, then 0.
  - `time_next_tx`=1000 from the next cycle.
  - `out`=0 during reset.
- Seed 7'h01, taps (−8, 96, −24) LSB, `time_curr` stepped 0, 1000, 2000, …:
  - Events 1–5: `out`=−64.
  - Event 6: −80 (`nxt`=1).
  - Event 7: 112.
  - Event 8: 80.
  - `bit_out` sequence over events 1–8 = 0,0,0,0,0,0,1,1.
- `tx_setting` toggled mid-UI: `out` is unchanged until the next event, then reflects the new taps.
- `time_curr` jumps from 0 to 2500 while `t_sched`=1000:
  - Two consecutive event cycles.
  - `err_late`=1 and stays set.
  - `t_sched` ends at 3000.
- `T0`=all-ones − 500, `UI_PERIOD`=1000:
  - First event sets `err_ovf`.
  - `time_next_tx` = all-ones.
  - No later events; `out` holds its last value.
- Assert `rst` during an event cycle:
  - The event is discarded.
  - Next cycle: `out`=0, `time_next_tx`=T0, both error flags cleared.

Source files
------------

// File: rtl/tx_ffe_source_pkg.sv
// Shared widths, types and FFE tap table for the emulated transmitter.
package tx_ffe_source_pkg;

    localparam int unsigned TIME_WIDTH       = 32;
    localparam int unsigned FILTER_IN_WIDTH  = 16;
    localparam int unsigned TX_SETTING_WIDTH = 2;
    localparam int unsigned NUM_TX_SETTINGS  = 4;
    localparam int unsigned NUM_TAPS         = 3;
    localparam int unsigned PRBS_WIDTH       = 7;

    typedef logic [TIME_WIDTH-1:0]              time_t;
    typedef logic signed [FILTER_IN_WIDTH-1:0]  filter_in_t;
    typedef logic [TX_SETTING_WIDTH-1:0]        tx_setting_t;
    typedef logic [PRBS_WIDTH-1:0]              prbs7_t;

    // Symbol window: nxt is the pre-cursor lookahead, post the oldest bit.
    typedef struct packed {
        logic nxt;
        logic main;
        logic post;
    } ffe_win_t;

    localparam prbs7_t PRBS7_SEED_DEFAULT = 7'h01;

    localparam filter_in_t FILTER_MAX = {1'b0, {(FILTER_IN_WIDTH-1){1'b1}}};
    localparam filter_in_t FILTER_MIN = {1'b1, {(FILTER_IN_WIDTH-1){1'b0}}};

    // Tap sets indexed by tx_setting; each entry is {pre, main, post}.
    localparam filter_in_t TX_TAPS [NUM_TX_SETTINGS][NUM_TAPS] = '{
        '{-16'sd8,     16'sd96,    -16'sd24},
        '{ 16'sd0,     16'sd128,    16'sd0},
        '{-16'sd16,    16'sd80,    -16'sd32},
        '{-16'sd20000, 16'sd32000, -16'sd20000}
    };

endpackage

// File: rtl/tx_ffe_source_if.sv
// Transmitter <-> time manager / channel filter signal bundle.
interface tx_ffe_source_if;
    import tx_ffe_source_pkg::*;

    time_t       time_curr;
    tx_setting_t tx_setting;
    time_t       time_next_tx;
    logic        time_eq_out;
    filter_in_t  out;
    logic        bit_out;
    logic        err_late;
    logic        err_ovf;

    modport master (
        input  time_curr, tx_setting,
        output time_next_tx, time_eq_out, out, bit_out, err_late, err_ovf
    );

    modport slave (
        output time_curr, tx_setting,
        input  time_next_tx, time_eq_out, out, bit_out, err_late, err_ovf
    );

endinterface

// File: rtl/prbs7_gen.sv
// PRBS7 (x^7 + x^6 + 1) generator, one step per asserted advance.
module prbs7_gen
    import tx_ffe_source_pkg::*;
(
    input  logic   clk_sys,
    input  logic   rst,
    input  logic   advance,
    input  prbs7_t seed,
    output logic   fb,
    output prbs7_t state
);

    assign fb = state[6] ^ state[5];

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state <= seed;
        end else if (advance) begin
            state <= {state[5:0], fb};
        end
    end

endmodule

// File: rtl/tx_ffe_source.sv
// Emulated transmitter: one PRBS7 symbol per UI event, shaped by a 3-tap FFE
// and presented in channel-filter format together with its event strobe.
module tx_ffe_source
    import tx_ffe_source_pkg::*;
#(
    parameter time_t  UI_PERIOD = TIME_WIDTH'(1000),
    parameter time_t  T0        = '0,
    parameter prbs7_t PRBS_SEED = PRBS7_SEED_DEFAULT
) (
    input  logic            clk_sys,
    input  logic            rst,
    tx_ffe_source_if.master bus
);

    localparam int unsigned ACC_W = FILTER_IN_WIDTH + 2;

    time_t                   t_sched;
    ffe_win_t                win;
    filter_in_t              out_q;
    logic                    bit_q;
    logic                    err_late_q;
    logic                    err_ovf_q;
    logic                    done;

    logic                    fb;
    prbs7_t                  prbs_state_unused;
    logic                    event_c;
    logic [TIME_WIDTH:0]     t_sum_c;
    ffe_win_t                win_next_c;
    logic signed [ACC_W-1:0] acc_c;
    filter_in_t              sat_c;

    // A symbol bit selects +coef (1) or -coef (0); no multiplier needed.
    function automatic logic signed [ACC_W-1:0] signed_tap(input logic b, input filter_in_t coef);
        return b ? ACC_W'(coef) : -ACC_W'(coef);
    endfunction

    prbs7_gen u_prbs (
        .clk_sys (clk_sys),
        .rst     (rst),
        .advance (event_c),
        .seed    (PRBS_SEED),
        .fb      (fb),
        .state   (prbs_state_unused)
    );

    // Event detect, schedule advance and FFE sum on the post-shift window.
    always_comb begin
        event_c    = !done && (bus.time_curr >= t_sched);
        t_sum_c    = {1'b0, t_sched} + {1'b0, UI_PERIOD};
        win_next_c = '{nxt: fb, main: win.nxt, post: win.main};
        acc_c      = signed_tap(win_next_c.nxt,  TX_TAPS[bus.tx_setting][0])
                   + signed_tap(win_next_c.main, TX_TAPS[bus.tx_setting][1])
                   + signed_tap(win_next_c.post, TX_TAPS[bus.tx_setting][2]);
        if (acc_c > ACC_W'(FILTER_MAX)) begin
            sat_c = FILTER_MAX;
        end else if (acc_c < ACC_W'(FILTER_MIN)) begin
            sat_c = FILTER_MIN;
        end else begin
            sat_c = FILTER_IN_WIDTH'(acc_c);
        end
    end

    // The tap set only matters at an event; out_q holds its effect until the next one.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            t_sched    <= T0;
            win        <= '0;
            out_q      <= '0;
            bit_q      <= 1'b0;
            err_late_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            done       <= 1'b0;
        end else if (event_c) begin
            win   <= win_next_c;
            out_q <= sat_c;
            bit_q <= win_next_c.main;
            if (bus.time_curr > t_sched) begin
                err_late_q <= 1'b1;
            end
            if (t_sum_c[TIME_WIDTH]) begin
                t_sched   <= '1;
                err_ovf_q <= 1'b1;
                done      <= 1'b1;
            end else begin
                t_sched <= t_sum_c[TIME_WIDTH-1:0];
            end
        end
    end

    assign bus.time_next_tx = t_sched;
    assign bus.time_eq_out  = event_c;
    assign bus.out          = out_q;
    assign bus.bit_out      = bit_q;
    assign bus.err_late     = err_late_q;
    assign bus.err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_tx_ffe_source.sv
// Bench for tx_ffe_source: table vectors, hand sequences and a model scoreboard.
module tb_tx_ffe_source;
    import tx_ffe_source_pkg::*;

    localparam time_t ALL_ONES = '1;
    localparam time_t B_T0     = ALL_ONES - TIME_WIDTH'(500);

    typedef struct {
        int   out;
        logic bit_v;
        time_t next;
        logic late;
        logic ovf;
    } exp_t;

    typedef struct {
        time_t tc;
        int    s;
        logic  ev;
        int    out;
        logic  bit_v;
        time_t next;
    } vec_t;

    logic clk_sys = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    tx_ffe_source_if bus_a ();
    tx_ffe_source_if bus_b ();

    tx_ffe_source #(.UI_PERIOD(TIME_WIDTH'(1000)), .T0('0), .PRBS_SEED(7'h01)) dut_a (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus_a)
    );

    tx_ffe_source #(.UI_PERIOD(TIME_WIDTH'(1000)), .T0(B_T0), .PRBS_SEED(7'h01)) dut_b (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus_b)
    );

    always #5 clk_sys = ~clk_sys;

    // Independent reference model of dut_a
    int    taps_m [4][3] = '{'{-8, 96, -24}, '{0, 128, 0}, '{-16, 80, -32}, '{-20000, 32000, -20000}};
    time_t m_sched;
    logic [6:0] m_prbs;
    logic [2:0] m_win;
    int    m_out;
    logic  m_bit, m_late, m_ovf, m_done;
    exp_t  sb_q [$];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input logic b);
        return b ? 1 : -1;
    endfunction

    task automatic model_reset();
        m_sched = '0; m_prbs = 7'h01; m_win = '0; m_out = 0;
        m_bit = 1'b0; m_late = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_event(input time_t tc, input int s);
        logic fb;
        longint sum;
        int acc;
        fb     = m_prbs[6] ^ m_prbs[5];
        m_prbs = {m_prbs[5:0], fb};
        m_win  = {fb, m_win[2:1]};
        acc    = sgn(m_win[2]) * taps_m[s][0] + sgn(m_win[1]) * taps_m[s][1] + sgn(m_win[0]) * taps_m[s][2];
        m_out  = (acc > 32767) ? 32767 : ((acc < -32768) ? -32768 : acc);
        m_bit  = m_win[1];
        if (tc > m_sched) m_late = 1'b1;
        sum = longint'(m_sched) + 1000;
        if (sum > longint'(ALL_ONES)) begin
            m_sched = '1; m_ovf = 1'b1; m_done = 1'b1;
        end else begin
            m_sched = time_t'(sum);
        end
    endtask

    // One clock cycle on dut_a: drive, check strobe, advance model, check outputs.
    task automatic cyc(input time_t tc, input int s, input logic r, output logic ev_seen);
        exp_t e;
        logic m_ev;
        bus_a.time_curr  = tc;
        bus_a.tx_setting = tx_setting_t'(s);
        rst = r;
        #1;
        m_ev    = !m_done && (tc >= m_sched);
        ev_seen = bus_a.time_eq_out;
        if (!r) chk("time_eq_out", 64'(ev_seen), 64'(m_ev));
        if (r) begin
            model_reset();
        end else if (m_ev) begin
            model_event(tc, s);
            e = '{m_out, m_bit, m_sched, m_late, m_ovf};
            sb_q.push_back(e);
        end
        @(posedge clk_sys);
        #1;
        if (ev_seen && !r) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_pop: DUT event with no expected entry (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_out",      64'(bus_a.out),          64'(e.out));
                chk("sb_bit_out",  64'(bus_a.bit_out),      64'(e.bit_v));
                chk("sb_next",     64'(bus_a.time_next_tx), 64'(e.next));
                chk("sb_err_late", 64'(bus_a.err_late),     64'(e.late));
                chk("sb_err_ovf",  64'(bus_a.err_ovf),      64'(e.ovf));
            end
        end
        chk("out",          64'(bus_a.out),          64'(m_out));
        chk("bit_out",      64'(bus_a.bit_out),      64'(m_bit));
        chk("time_next_tx", 64'(bus_a.time_next_tx), 64'(m_sched));
        chk("err_late",     64'(bus_a.err_late),     64'(m_late));
        chk("err_ovf",      64'(bus_a.err_ovf),      64'(m_ovf));
    endtask

    initial begin
        vec_t  tbl [15];
        logic  ev, ev_a, ev_b, ev_c;
        time_t a_tc;

        tbl = '{
            '{0,     0, 1'b1,  -64,    1'b0, 1000},
            '{0,     0, 1'b0,  -64,    1'b0, 1000},
            '{1000,  0, 1'b1,  -64,    1'b0, 2000},
            '{2000,  0, 1'b1,  -64,    1'b0, 3000},
            '{3000,  0, 1'b1,  -64,    1'b0, 4000},
            '{4000,  0, 1'b1,  -64,    1'b0, 5000},
            '{5000,  0, 1'b1,  -80,    1'b0, 6000},
            '{6000,  0, 1'b1,  112,    1'b1, 7000},
            '{7000,  0, 1'b1,  80,     1'b1, 8000},
            '{8000,  0, 1'b1,  -112,   1'b0, 9000},
            '{9000,  0, 1'b1,  -64,    1'b0, 10000},
            '{10000, 0, 1'b1,  -64,    1'b0, 11000},
            '{11000, 0, 1'b1,  -80,    1'b0, 12000},
            '{12000, 3, 1'b1,  32767,  1'b1, 13000},
            '{13000, 3, 1'b1,  -32768, 1'b0, 14000}
        };

        rst = 1'b1;
        bus_a.time_curr = '0; bus_a.tx_setting = '0;
        bus_b.time_curr = '0; bus_b.tx_setting = '0;
        model_reset();
        @(posedge clk_sys);
        #1;

        // Reset hold
        for (int i = 0; i < 3; i++) cyc(0, 0, 1'b1, ev);
        chk("rst_out_a",  64'(bus_a.out),          64'(0));
        chk("rst_next_a", 64'(bus_a.time_next_tx), 64'(0));
        chk("rst_out_b",  64'(bus_b.out),          64'(0));
        chk("rst_next_b", 64'(bus_b.time_next_tx), 64'(B_T0));

        // PRBS/FFE reference vectors, including saturation on tap set 3
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].tc, tbl[i].s, 1'b0, ev);
            chk($sformatf("tbl%0d_ev", i),   64'(ev),                 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_out", i),  64'(bus_a.out),          64'(tbl[i].out));
            chk($sformatf("tbl%0d_bit", i),  64'(bus_a.bit_out),      64'(tbl[i].bit_v));
            chk($sformatf("tbl%0d_next", i), 64'(bus_a.time_next_tx), 64'(tbl[i].next));
        end
        chk("b_idle_ev", 64'(bus_b.time_eq_out), 64'(0));

        // Tap set change mid-UI takes effect only at the next event
        cyc(14000, 0, 1'b0, ev);
        chk("mid_ev15_out", 64'(bus_a.out), 64'(128));
        chk("mid_ev15_bit", 64'(bus_a.bit_out), 64'(1));
        cyc(14500, 2, 1'b0, ev);
        chk("mid_noev", 64'(ev), 64'(0));
        chk("mid_hold_out", 64'(bus_a.out), 64'(128));
        cyc(15000, 2, 1'b0, ev);
        chk("mid_ev16_out", 64'(bus_a.out), 64'(-96));
        chk("mid_ev16_bit", 64'(bus_a.bit_out), 64'(0));

        // Time jump 0 -> 2500 with t_sched at 1000
        cyc(0, 0, 1'b1, ev);
        cyc(0, 0, 1'b0, ev);
        chk("late_first_next", 64'(bus_a.time_next_tx), 64'(1000));
        chk("late_first_flag", 64'(bus_a.err_late), 64'(0));
        cyc(2500, 0, 1'b0, ev_a);
        cyc(2500, 0, 1'b0, ev_b);
        cyc(2500, 0, 1'b0, ev_c);
        chk("late_ev_a", 64'(ev_a), 64'(1));
        chk("late_ev_b", 64'(ev_b), 64'(1));
        chk("late_ev_c", 64'(ev_c), 64'(0));
        chk("late_next", 64'(bus_a.time_next_tx), 64'(3000));
        chk("late_flag", 64'(bus_a.err_late), 64'(1));

        // Reset asserted in an event cycle discards the event
        cyc(3000, 0, 1'b1, ev);
        chk("rstev_pending", 64'(ev), 64'(1));
        chk("rstev_out",  64'(bus_a.out),          64'(0));
        chk("rstev_next", 64'(bus_a.time_next_tx), 64'(0));
        chk("rstev_late", 64'(bus_a.err_late),     64'(0));
        chk("rstev_ovf",  64'(bus_a.err_ovf),      64'(0));
        cyc(0, 0, 1'b0, ev);
        chk("rstev_restart_out", 64'(bus_a.out), 64'(-64));

        // Random time steps (incl. late/back-to-back) and tap sets
        a_tc = '0;
        for (int i = 0; i < 300; i++) begin
            a_tc = a_tc + TIME_WIDTH'($urandom_range(0, 1500));
            cyc(a_tc, int'($urandom_range(0, 3)), 1'b0, ev);
        end

        // Schedule overflow on dut_b
        bus_b.time_curr = B_T0;
        #1;
        chk("ovf_ev", 64'(bus_b.time_eq_out), 64'(1));
        cyc(a_tc, 0, 1'b0, ev);
        chk("ovf_flag", 64'(bus_b.err_ovf),      64'(1));
        chk("ovf_next", 64'(bus_b.time_next_tx), 64'(ALL_ONES));
        chk("ovf_out",  64'(bus_b.out),          64'(-64));
        chk("ovf_late", 64'(bus_b.err_late),     64'(0));
        bus_b.time_curr = ALL_ONES;
        for (int i = 0; i < 3; i++) begin
            cyc(a_tc, 0, 1'b0, ev);
            chk($sformatf("ovf_noev%0d", i), 64'(bus_b.time_eq_out), 64'(0));
            chk($sformatf("ovf_hold%0d", i), 64'(bus_b.out),         64'(-64));
            chk($sformatf("ovf_sticky%0d", i), 64'(bus_b.err_ovf),   64'(1));
        end

        chk("sb_leftover", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
